// File: rtl/serial_compare.sv
`default_nettype none
// ============================================================================
// Module      : serial_compare
// Description : Multi-cycle magnitude comparator. Two WIDTH-bit operands are
//               compared MSB-first, DIGIT bits per clock, in unsigned or
//               two's-complement mode. Reports one-hot AEB/ASB/AGB flags
//               together with a single-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_compare #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             AEB,
    output logic             ASB,
    output logic             AGB
);

    localparam int c_steps = WIDTH / DIGIT;
    localparam int c_cw    = $clog2(c_steps) + 1;

    localparam logic [c_cw-1:0] c_last     = c_cw'(c_steps - 1);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

    // Flipping the sign bit maps two's-complement order onto unsigned order
    localparam logic [WIDTH-1:0] c_sign_mask = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [c_cw-1:0]  r_cnt;
    logic             r_decided;
    logic             r_lt;
    logic             r_gt;

    logic             r_busy;
    logic             r_done;
    logic             r_aeb;
    logic             r_asb;
    logic             r_agb;

    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic             w_differ;
    logic             w_lt_step;
    logic             w_gt_step;
    logic             w_last;
    logic [WIDTH-1:0] w_a_load;
    logic [WIDTH-1:0] w_b_load;

    // Current digit pair and the decision it produces; an earlier decision sticks
    always_comb begin
        w_da      = r_sa[WIDTH-1 -: DIGIT];
        w_db      = r_sb[WIDTH-1 -: DIGIT];
        w_differ  = (w_da != w_db);
        w_gt_step = r_decided ? r_gt : (w_differ && (w_da > w_db));
        w_lt_step = r_decided ? r_lt : (w_differ && (w_da < w_db));
        w_last    = (r_cnt == c_last);
        w_a_load  = is_signed ? (A ^ c_sign_mask) : A;
        w_b_load  = is_signed ? (B ^ c_sign_mask) : B;
    end

    // Next-state logic: IDLE waits for start, RUN lasts exactly c_steps cycles
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_nxt = c_RUN;
            c_RUN:   if (w_last) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operand capture, digit-serial scan and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa      <= '0;
            r_sb      <= '0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
            r_gt      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aeb     <= 1'b0;
            r_asb     <= 1'b0;
            r_agb     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sa      <= w_a_load;
                        r_sb      <= w_b_load;
                        r_cnt     <= '0;
                        r_decided <= 1'b0;
                        r_lt      <= 1'b0;
                        r_gt      <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                c_RUN: begin
                    r_sa      <= r_sa << DIGIT;
                    r_sb      <= r_sb << DIGIT;
                    r_cnt     <= r_cnt + c_cnt_one;
                    r_decided <= r_decided | w_differ;
                    r_lt      <= w_lt_step;
                    r_gt      <= w_gt_step;
                    if (w_last) begin
                        // Final digit's decision is folded in directly
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_agb  <= w_gt_step;
                        r_asb  <= w_lt_step;
                        r_aeb  <= ~(w_gt_step | w_lt_step);
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign AEB  = r_aeb;
    assign ASB  = r_asb;
    assign AGB  = r_agb;

endmodule
`default_nettype wire

// File: tb/tb_serial_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_compare
// Description : Directed and random stimulus for serial_compare (8-bit,
//               2-bit digits) with a queue scoreboard of expected flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_compare;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int STEPS = WIDTH / DIGIT;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             AEB;
    logic             ASB;
    logic             AGB;

    int          n_cmp;
    int          n_err;
    int          m_cnt;
    logic [2:0]  m_flags;
    logic [2:0]  q[$];

    serial_compare #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .AEB       (AEB),
        .ASB       (ASB),
        .AGB       (AGB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference compare, flags ordered {AEB, ASB, AGB}
    function automatic logic [2:0] golden(input logic [7:0] a, input logic [7:0] b,
                                          input logic sg);
        logic lt;
        logic gt;
        if (sg) begin
            lt = ($signed(a) < $signed(b));
            gt = ($signed(a) > $signed(b));
        end else begin
            lt = (a < b);
            gt = (a > b);
        end
        return {~(lt | gt), lt, gt};
    endfunction

    function automatic logic [7:0] pick8();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model, then check
    task automatic step(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic sg, input logic r);
        logic exp_done;
        start     = s;
        A         = a;
        B         = b;
        is_signed = sg;
        rst       = r;
        exp_done  = 1'b0;
        if (r) begin
            m_cnt   = 0;
            m_flags = 3'b000;
            q.delete();
        end else if (m_cnt == 0) begin
            if (s) begin
                q.push_back(golden(a, b, sg));
                m_cnt = STEPS;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) exp_done = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("done", 32'(done), 32'(exp_done));
        chk("busy_done_excl", 32'(busy & done), 32'd0);
        if (exp_done && q.size() > 0) begin
            m_flags = q.pop_front();
            chk("onehot", 32'($countones({AEB, ASB, AGB})), 32'd1);
        end
        chk("flags", 32'({AEB, ASB, AGB}), 32'(m_flags));
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic sg);
        step(1'b1, a, b, sg, 1'b0);
        // Operands wander during RUN and must not matter
        for (int i = 0; i < STEPS; i++) step(1'b0, 8'($urandom), 8'($urandom), ~sg, 1'b0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        m_cnt     = 0;
        m_flags   = 3'b000;
        start     = 1'b0;
        A         = '0;
        B         = '0;
        is_signed = 1'b0;
        rst       = 1'b1;

        // Reset state
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Equal, mode switch, first-difference priority
        run_one(8'h5A, 8'h5A, 1'b0);
        run_one(8'h80, 8'h7F, 1'b0);
        run_one(8'h80, 8'h7F, 1'b1);
        run_one(8'hFF, 8'h00, 1'b1);
        run_one(8'hFF, 8'h00, 1'b0);
        run_one(8'h40, 8'h3F, 1'b0);
        run_one(8'h3F, 8'h40, 1'b0);
        run_one(8'h81, 8'h81, 1'b1);
        run_one(8'h01, 8'h02, 1'b0);

        // Start held high with operands changing every cycle
        for (int i = 0; i < 20; i++) step(1'b1, pick8(), pick8(), 1'($urandom), 1'b0);
        for (int i = 0; i < STEPS + 1; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset at the second RUN edge discards the result
        step(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        step(1'b0, 8'h10, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_one(8'h10, 8'h20, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), pick8(), pick8(), 1'($urandom),
                 1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < STEPS + 1; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        chk("drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_compare.md
# serial_compare

Parametrised, multi-cycle magnitude comparator that generalises the lab's 8-bit combinational A/B comparator. It accepts two WIDTH-bit operands on a start pulse and compares them MSB-first, DIGIT bits per clock. It then reports one-hot equal/less/greater flags with a done pulse, in either unsigned or two's-complement mode. It is the building block for the follow-on sorting and min/max experiments, where operand width exceeds what one combinational stage should span.

## Interface
- WIDTH, 8, operand width in bits; WIDTH >= 2.
- DIGIT, 2, bits compared per clock; WIDTH % DIGIT == 0 is required. STEPS = WIDTH/DIGIT.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse; result valid and updated.
- AEB  output  1  A == B.
- ASB  output  1  A < B.
- AGB  output  1  A > B.

## Operation
- States: IDLE, RUN. There is no separate DONE state.
- IDLE with start=1 at an edge:
  - Latch A and B into shift registers. If is_signed=1, invert bit WIDTH-1 of both latched copies (offset-binary mapping), so the unsigned digit compare gives the signed order.
  - Clear decided, lt and gt. Load step counter = 0. Go to RUN.
- RUN, each edge:
  - Compare the top DIGIT bits of both shift registers.
  - If decided=0 and the digits differ: set decided=1, gt = (digitA > digitB), lt = !gt.
  - If decided=1, the digits are ignored; the first differing digit wins.
  - Shift both registers left by DIGIT. Increment the counter.
- Final RUN edge (counter == STEPS-1):
  - Write the result using this edge's digit decision: AGB=gt, ASB=lt, AEB = !(gt|lt).
  - Assert done for one cycle, deassert busy, return to IDLE.
- AEB/ASB/AGB change only at done edges and hold between comparisons. They are one-hot after the first completion.
- start while busy=1 is ignored and not queued. A/B/is_signed changes during RUN have no effect.
- DIGIT == WIDTH is legal: STEPS=1, single RUN cycle.

## Timing
- Reset values: busy=0, done=0, AEB=0, ASB=0, AGB=0, state IDLE, counter 0.
- Start accepted at edge E0. busy=1 from E0 until E_STEPS. done=1 and new flags visible after E_STEPS, so latency = STEPS cycles from the accepting edge.
- done and busy never both 1.
- Back-to-back operation: start=1 in the done cycle is accepted (state is IDLE). With start held high, the maximum rate is one result per STEPS+1 cycles.
- rst=1 at any edge, including mid-RUN: all state and outputs return to reset values, the in-flight result is discarded, and no done is produced. rst has priority over start.
- Counter width clog2(STEPS)+1. No combinational path from inputs to outputs.

## Test plan
- Equal case: WIDTH=8, DIGIT=2, A=B=0x5A, is_signed=0, start one cycle -> done exactly 4 cycles after the accepting edge, AEB=1, ASB=0, AGB=0; busy high for 4 cycles.
- Mode switch: A=0x80, B=0x7F. is_signed=0 -> AGB=1. Repeat with is_signed=1 -> ASB=1. Also A=0xFF, B=0x00, is_signed=1 -> ASB=1 (-1 < 0).
- First-difference priority: A=0x40, B=0x3F, unsigned. The MSB digit differs (01 vs 00) and later digits favour B -> AGB=1.
- Handshake: start held high for 20 cycles while A/B change every cycle -> done pulses every 5 cycles. Each result matches the operands present at its accepting edge; starts during busy are ignored.
- Reset mid-operation: start with A=0x10, B=0x20; assert rst at the 2nd RUN edge -> busy=0 next cycle, no done, AEB/ASB/AGB=0. A subsequent start completes normally.
- Random sweep: 10k random operand/mode pairs for (WIDTH,DIGIT) = (8,1), (8,2), (8,8), (16,4) -> flags match a signed/unsigned golden compare, exactly one flag high, latency = STEPS every time.
